// File: rtl/imem_responder.sv
// imem_responder
//   Instruction-memory responder. It accepts one fetch at a time over a
//   valid/ready request channel and answers LATENCY cycles later on a
//   valid/ready response channel. The word array is loaded through a
//   separate write port that runs independently of the fetch FSM.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, 16..4096)
//   LATENCY      cycles from request accept to rsp_valid (1..7)
//
// Ports
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  fetch request present
//   req_ready  responder idle and able to accept a request
//   req_addr   byte address to fetch
//   rsp_valid  response present
//   rsp_ready  requester consumes the response
//   rsp_data   fetched instruction word (0 when no response or on error)
//   rsp_err    address misaligned or out of range
//   wr_en      program-load write strobe
//   wr_addr    program-load byte address
//   wr_data    program-load data word
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request outstanding, req_ready=1
// WAIT  | request captured, latency counter running down
// RESP  | rsp_valid=1, holding captured word until rsp_ready
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] data_q;
  logic        err_q;
  logic        capture;

  logic [31:0] mem [DEPTH_WORDS];

  // Aligned and below 4*DEPTH_WORDS: all bits above the word index are zero.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a[31:AW+2] == '0);
  endfunction

  // Program-load port; bad addresses are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (wr_en && addr_ok(wr_addr)) begin
      mem[wr_addr[AW+1:2]] <= wr_data;
    end
  end

  // Capture on the accept edge. The memory write above lands on the same
  // edge through a non-blocking update, so this read sees the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (capture) begin
      if (addr_ok(req_addr)) begin
        data_q <= mem[req_addr[AW+1:2]];
        err_q  <= 1'b0;
      end else begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  // Response payload is forced to zero whenever no response is presented.
  assign rsp_data  = rsp_valid ? data_q : 32'h0000_0000;
  assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder
//   Three responders (LATENCY 2, 1 and 7, DEPTH_WORDS 256) with separate
//   stimulus. A word-array model tracks what each memory should hold; fetch
//   expectations come from either a constant table or that model.
module tb_imem_responder;

  localparam int NI = 3;
  localparam int LAT [NI] = '{2, 1, 7};

  logic        clk;
  logic        reset;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic [31:0] req_addr  [NI];
  logic        rsp_valid [NI];
  logic        rsp_ready [NI];
  logic [31:0] rsp_data  [NI];
  logic        rsp_err   [NI];
  logic        wr_en     [NI];
  logic [31:0] wr_addr   [NI];
  logic [31:0] wr_data   [NI];

  logic [31:0] mem_m [NI][256];

  int tests;
  int fails;

  typedef struct {
    logic [31:0] addr;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0])
  );

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1])
  );

  imem_responder #(.DEPTH_WORDS(256), .LATENCY(7)) u_l7 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_data(rsp_data[2]),
    .rsp_err(rsp_err[2]), .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: aligned addresses below 1024 bytes land in the word array.
  task automatic model_wr(input int k, input logic [31:0] a, input logic [31:0] d);
    if (a[1:0] == 2'b00 && a < 32'd1024) mem_m[k][a[9:2]] = d;
  endtask

  task automatic model_rd(input int k, input logic [31:0] a,
                          output logic [31:0] d, output logic e);
    e = (a[1:0] != 2'b00) || (a >= 32'd1024);
    d = e ? 32'h0 : mem_m[k][a[9:2]];
  endtask

  task automatic drive_wr(input int k, input logic [31:0] a, input logic [31:0] d);
    wr_en[k]   = 1'b1;
    wr_addr[k] = a;
    wr_data[k] = d;
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d);
    drive_wr(k, a, d);
    tick();
    model_wr(k, a, d);
    wr_en[k] = 1'b0;
  endtask

  // One complete fetch. wmode 0: no writes; 1: write wdat to addr on the
  // accept edge only; 2: random writes to addr plus req_valid noise on every
  // edge of the transaction. bp = cycles rsp_ready is held low in RESP.
  task automatic fetch(input int k, input logic [31:0] addr,
                       input logic [31:0] exp_d, input logic exp_e,
                       input int bp, input int wmode, input logic [31:0] wdat,
                       input string nm);
    int lat;
    logic [31:0] w;
    w = 32'h0;
    check({nm, " req_ready before"}, 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_addr[k]  = addr;
    if (wmode != 0) begin
      w = (wmode == 1) ? wdat : $urandom;
      drive_wr(k, addr, w);
    end
    tick();
    if (wmode != 0) model_wr(k, addr, w);
    req_valid[k] = 1'b0;
    req_addr[k]  = $urandom;
    wr_en[k]     = 1'b0;
    lat = 0;
    while (!rsp_valid[k] && lat < 16) begin
      check({nm, " wait rsp_data"}, rsp_data[k], 32'h0);
      check({nm, " wait rsp_err"}, 32'(rsp_err[k]), 32'd0);
      check({nm, " wait req_ready"}, 32'(req_ready[k]), 32'd0);
      if (wmode == 2) begin
        w = $urandom;
        drive_wr(k, addr, w);
        req_valid[k] = 1'($urandom_range(0, 1));
      end
      tick();
      if (wmode == 2) model_wr(k, addr, w);
      wr_en[k] = 1'b0;
      req_valid[k] = 1'b0;
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(LAT[k]));
    if (rsp_valid[k]) begin
      for (int i = 0; i <= bp; i++) begin
        rsp_ready[k] = (i == bp);
        if (wmode == 2) begin
          w = $urandom;
          drive_wr(k, addr, w);
          req_valid[k] = 1'($urandom_range(0, 1));
        end
        check({nm, " rsp_valid"}, 32'(rsp_valid[k]), 32'd1);
        check({nm, " rsp_data"}, rsp_data[k], exp_d);
        check({nm, " rsp_err"}, 32'(rsp_err[k]), 32'(exp_e));
        check({nm, " resp req_ready"}, 32'(req_ready[k]), 32'd0);
        tick();
        if (wmode == 2) model_wr(k, addr, w);
        wr_en[k]     = 1'b0;
        req_valid[k] = 1'b0;
      end
      rsp_ready[k] = 1'b0;
      check({nm, " rsp_valid after"}, 32'(rsp_valid[k]), 32'd0);
      check({nm, " req_ready after"}, 32'(req_ready[k]), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] a;
    int          r;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = 32'h0; rsp_ready[k] = 1'b0;
      wr_en[k] = 1'b0; wr_addr[k] = 32'h0; wr_data[k] = 32'h0;
    end
    #3;
    for (int k = 0; k < NI; k++) begin
      check("reset req_ready", 32'(req_ready[k]), 32'd1);
      check("reset rsp_valid", 32'(rsp_valid[k]), 32'd0);
      check("reset rsp_data", rsp_data[k], 32'h0);
      check("reset rsp_err", 32'(rsp_err[k]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Program load, including writes that must be dropped.
    wr(0, 32'h10,  32'h0050_0093);
    wr(0, 32'h3FC, 32'hDEAD_BEEF);
    wr(0, 32'h0,   32'h1234_5678);
    wr(0, 32'h13,  32'hFFFF_FFFF);
    wr(0, 32'h410, 32'hFFFF_FFFF);
    wr(0, 32'h401, 32'hFFFF_FFFF);

    vecs[0] = '{32'h10,        1'b0, 32'h0050_0093};
    vecs[1] = '{32'h12,        1'b1, 32'h0};
    vecs[2] = '{32'h400,       1'b1, 32'h0};
    vecs[3] = '{32'h3FC,       1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{32'h0,         1'b0, 32'h1234_5678};
    vecs[5] = '{32'hFFFF_FFFC, 1'b1, 32'h0};
    vecs[6] = '{32'h401,       1'b1, 32'h0};
    vecs[7] = '{32'h13,        1'b1, 32'h0};
    for (int i = 0; i < 8; i++) begin
      fetch(0, vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err, 0, 0, 32'h0, $sformatf("vec%0d", i));
    end

    // Read-before-write on the accept edge, then the new value is visible.
    wr(0, 32'h20, 32'hAAAA_0000);
    fetch(0, 32'h20, 32'hAAAA_0000, 1'b0, 0, 1, 32'h5555_FFFF, "rbw first");
    fetch(0, 32'h20, 32'h5555_FFFF, 1'b0, 0, 0, 32'h0, "rbw second");

    // Backpressure with writes to the same word and req_valid noise.
    model_rd(0, 32'h10, d, e);
    fetch(0, 32'h10, d, e, 5, 2, 32'h0, "backpressure");
    model_rd(0, 32'h10, d, e);
    fetch(0, 32'h10, d, e, 0, 0, 32'h0, "after backpressure");

    // Reset during WAIT aborts the request; memory survives.
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0;
    tick();
    req_valid[0] = 1'b0;
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midwait reset req_ready", 32'(req_ready[0]), 32'd1);
    check("midwait reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("midwait reset rsp_data", rsp_data[0], 32'h0);
    check("midwait reset rsp_err", 32'(rsp_err[0]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("no rsp after reset", 32'(rsp_valid[0]), 32'd0);
      tick();
    end
    fetch(0, 32'h0, 32'h1234_5678, 1'b0, 0, 0, 32'h0, "post reset fetch");

    // Randomized sweep on every latency variant.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 32; i++) wr(k, 32'(i) << 2, $urandom);
      for (int n = 0; n < 25; n++) begin
        r = $urandom_range(0, 9);
        if (r < 7)       a = 32'($urandom_range(0, 31)) << 2;
        else if (r == 7) a = (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(1, 3));
        else if (r == 8) a = 32'd1024 + 32'($urandom_range(0, 4000));
        else             a = $urandom | 32'h8000_0000;
        model_rd(k, a, d, e);
        fetch(k, a, d, e, $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
              $sformatf("rand L%0d #%0d", LAT[k], n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
